// File: rtl/bytewrite_ram_pkg.sv
// Shared types and constants for the byte-write RAM port arbiter slice.
package bytewrite_ram_pkg;

  // Accept-to-response latency through the RAM read and output registers.
  localparam int RD_LAT = 3;

  // Tag id is wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Word width of the RAM port from its lane geometry.
  function automatic int data_width(input int nb_col, input int col_width);
    return nb_col * col_width;
  endfunction

endpackage

// File: rtl/bytewrite_ram_port_arbiter_rr_arbiter.sv
// Round-robin one-hot grant with a registered priority pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hold,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic            found;

  // First requesting index at or after the pointer, searching upward with wrap.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    cand     = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && !hold && req[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = cand;
        found       = 1'b1;
      end
    end
  end

  // Pointer moves just past the requester that was served, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/bytewrite_ram_port_arbiter.sv
// Shares one byte-write write-first RAM port among several requesters and
// routes each read result back to the requester that issued the op.
module bytewrite_ram_port_arbiter
  import bytewrite_ram_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int ADDR_W    = 10
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  arb_hold,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*NB_COL-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]             req_addr,
  input  logic [NUM_REQ*NB_COL*COL_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [NB_COL*COL_WIDTH-1:0]           rsp_rdata,
  output logic                                  busy,
  output logic                                  ram_en,
  output logic [NB_COL-1:0]                     ram_we,
  output logic [ADDR_W-1:0]                     ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]           ram_din,
  output logic                                  ram_regce,
  output logic                                  ram_rst,
  input  logic [NB_COL*COL_WIDTH-1:0]           ram_dout
);

  localparam int DATA_W = data_width(NB_COL, COL_WIDTH);
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]   grant_id;
  logic              accept;
  logic [NB_COL-1:0] sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  tag_t              tag_pipe [RD_LAT];
  logic [1:0]        rst_sr;

  // Reset forces the arbiter to grant nothing.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .hold     (arb_hold | ~rst_n),
    .advance  (accept),
    .grant    (req_ready),
    .grant_id (grant_id)
  );

  // Select the granted requester's op fields.
  always_comb begin
    accept    = |(req_valid & req_ready);
    sel_we    = req_we[int'(grant_id)*NB_COL +: NB_COL];
    sel_addr  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[int'(grant_id)*DATA_W +: DATA_W];
  end

  // Launch the accepted op onto the RAM port one cycle after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_en   <= 1'b0;
      ram_we   <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_en <= accept;
      ram_we <= accept ? sel_we : '0;
      if (accept) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_wdata;
      end
    end
  end

  // Carry the issuing requester's id alongside the op through the RAM latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0].valid <= accept;
      tag_pipe[0].id    <= TAG_ID_W'(grant_id);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Hold the RAM output register in reset for the reset cycle and one more.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_sr <= 2'b11;
    end else begin
      rst_sr <= {rst_sr[0], 1'b0};
    end
  end

  // Decode the last tag stage into a one-hot response and summarise activity.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_pipe[RD_LAT-1].valid &&
                     (tag_pipe[RD_LAT-1].id == TAG_ID_W'(i));
    end
    busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      busy = busy | tag_pipe[i].valid;
    end
    ram_regce = tag_pipe[RD_LAT-2].valid;
    ram_rst   = rst_sr[1];
    rsp_rdata = ram_dout;
  end

endmodule
